// File: rtl/axi4l_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi4l_regbank_pkg
// Brief   : Register map, constants and address decode for axi4l_regbank.
// Revision: 1.0 - initial release
// ============================================================================
package axi4l_regbank_pkg;

  localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;
  localparam logic [31:0] UNMAPPED_RDATA  = 32'hDEAD_BEEF;

  localparam logic [31:0] ADDR_VERSION    = 32'd0;
  localparam logic [31:0] ADDR_SCRATCH    = 32'd1;
  localparam logic [31:0] ADDR_CONTROL    = 32'd2;
  localparam logic [31:0] ADDR_IRQ_STATUS = 32'd3;
  localparam logic [31:0] ADDR_IRQ_ENABLE = 32'd4;
  localparam logic [31:0] ADDR_EVT_COUNT  = 32'd5;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_SOFT_RST_BIT = 1;
  localparam int IRQ_WIDTH         = 8;

  typedef enum logic [2:0] {
    SEL_VERSION,
    SEL_SCRATCH,
    SEL_CONTROL,
    SEL_IRQ_STATUS,
    SEL_IRQ_ENABLE,
    SEL_EVT_COUNT,
    SEL_NONE
  } reg_sel_t;

  function automatic reg_sel_t decode_addr(input logic [31:0] addr);
    reg_sel_t sel;
    case (addr)
      ADDR_VERSION:    sel = SEL_VERSION;
      ADDR_SCRATCH:    sel = SEL_SCRATCH;
      ADDR_CONTROL:    sel = SEL_CONTROL;
      ADDR_IRQ_STATUS: sel = SEL_IRQ_STATUS;
      ADDR_IRQ_ENABLE: sel = SEL_IRQ_ENABLE;
      ADDR_EVT_COUNT:  sel = SEL_EVT_COUNT;
      default:         sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4l_regbank_irq.sv
`default_nettype none
// ============================================================================
// Module  : axi4l_regbank_irq
// Brief   : Interrupt status (W1C, set-wins), enable register and irq output.
// Revision: 1.0 - initial release
// ============================================================================
module axi4l_regbank_irq
  import axi4l_regbank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_WIDTH-1:0] irq_event,
  input  logic                 enable_we,
  input  logic                 status_w1c,
  input  logic [IRQ_WIDTH-1:0] wr_data,
  output logic [IRQ_WIDTH-1:0] status,
  output logic [IRQ_WIDTH-1:0] enable,
  output logic                 irq
);

  logic [IRQ_WIDTH-1:0] clear_mask;
  logic [IRQ_WIDTH-1:0] status_next;

  // Event OR-ed in after the clear so a coincident set wins.
  always_comb begin
    clear_mask  = status_w1c ? wr_data : '0;
    status_next = (status & ~clear_mask) | irq_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
      enable <= '0;
      irq    <= 1'b0;
    end else begin
      status <= status_next;
      if (enable_we) begin
        enable <= wr_data;
      end
      irq <= |(status & enable);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4l_regbank.sv
`default_nettype none
// ============================================================================
// Module  : axi4l_regbank
// Brief   : Register bank with 1-cycle write/read ack, IRQ and event counter.
// Revision: 1.0 - initial release
// ============================================================================
module axi4l_regbank
  import axi4l_regbank_pkg::*;
#(
  parameter int          C_ADDR_WIDTH = 12,
  parameter int          C_DATA_WIDTH = 32,
  parameter logic [31:0] C_VERSION    = DEFAULT_VERSION
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [C_ADDR_WIDTH-3:0] wr_addr,
  input  logic                    wr_req,
  input  logic [3:0]              wr_be,
  input  logic [31:0]             wr_data,
  output logic                    wr_ack,
  input  logic [C_ADDR_WIDTH-3:0] rd_addr,
  input  logic                    rd_req,
  output logic [31:0]             rd_data,
  output logic                    rd_ack,
  input  logic [IRQ_WIDTH-1:0]    irq_event,
  input  logic                    cnt_event,
  output logic                    ctrl_enable,
  output logic                    ctrl_soft_rst,
  output logic                    irq
);

  if (C_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi4l_regbank: C_DATA_WIDTH must be 32");
  end

  reg_sel_t             wr_sel;
  reg_sel_t             rd_sel;
  logic                 scratch_we;
  logic                 control_we;
  logic                 irq_en_we;
  logic                 irq_w1c;
  logic                 evt_clear;
  logic [31:0]          evt_base;
  logic [31:0]          evt_next;
  logic [31:0]          rd_value;
  logic [31:0]          scratch;
  logic [31:0]          evt_count;
  logic [IRQ_WIDTH-1:0] irq_status;
  logic [IRQ_WIDTH-1:0] irq_enable;

  always_comb begin
    wr_sel     = decode_addr(32'(wr_addr));
    rd_sel     = decode_addr(32'(rd_addr));
    scratch_we = wr_req && (wr_sel == SEL_SCRATCH);
    control_we = wr_req && (wr_sel == SEL_CONTROL) && wr_be[0];
    irq_en_we  = wr_req && (wr_sel == SEL_IRQ_ENABLE) && wr_be[0];
    irq_w1c    = wr_req && (wr_sel == SEL_IRQ_STATUS) && wr_be[0];
    evt_clear  = wr_req && (wr_sel == SEL_EVT_COUNT) && wr_be[0];
  end

  // Clear is applied before the increment so clear+event yields 1.
  always_comb begin
    evt_base = evt_clear ? 32'd0 : evt_count;
    evt_next = evt_base;
    if (cnt_event && (evt_base != 32'hFFFF_FFFF)) begin
      evt_next = evt_base + 32'd1;
    end
  end

  always_comb begin
    rd_value = UNMAPPED_RDATA;
    case (rd_sel)
      SEL_VERSION:    rd_value = C_VERSION;
      SEL_SCRATCH:    rd_value = scratch;
      SEL_CONTROL:    rd_value = {31'd0, ctrl_enable};
      SEL_IRQ_STATUS: rd_value = {{(32-IRQ_WIDTH){1'b0}}, irq_status};
      SEL_IRQ_ENABLE: rd_value = {{(32-IRQ_WIDTH){1'b0}}, irq_enable};
      SEL_EVT_COUNT:  rd_value = evt_count;
      default:        rd_value = UNMAPPED_RDATA;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      scratch <= '0;
    end else if (scratch_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          scratch[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      ctrl_enable   <= 1'b0;
      ctrl_soft_rst <= 1'b0;
      evt_count     <= '0;
    end else begin
      wr_ack        <= wr_req;
      rd_ack        <= rd_req;
      ctrl_soft_rst <= control_we && wr_data[CTRL_SOFT_RST_BIT];
      evt_count     <= evt_next;
      if (rd_req) begin
        rd_data <= rd_value;
      end
      if (control_we) begin
        ctrl_enable <= wr_data[CTRL_ENABLE_BIT];
      end
    end
  end

  axi4l_regbank_irq u_irq (
    .clk        (aclk),
    .rst        (areset),
    .irq_event  (irq_event),
    .enable_we  (irq_en_we),
    .status_w1c (irq_w1c),
    .wr_data    (wr_data[IRQ_WIDTH-1:0]),
    .status     (irq_status),
    .enable     (irq_enable),
    .irq        (irq)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi4l_regbank.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4l_regbank
// Brief   : Directed self-checking bench for axi4l_regbank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi4l_regbank;

  localparam int AW = 10;

  logic        aclk = 1'b0;
  logic        areset;
  logic [AW-1:0] wr_addr;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [AW-1:0] rd_addr;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic [7:0]  irq_event;
  logic        cnt_event;
  logic        ctrl_enable;
  logic        ctrl_soft_rst;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4l_regbank dut (
    .aclk          (aclk),
    .areset        (areset),
    .wr_addr       (wr_addr),
    .wr_req        (wr_req),
    .wr_be         (wr_be),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .rd_addr       (rd_addr),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .irq_event     (irq_event),
    .cnt_event     (cnt_event),
    .ctrl_enable   (ctrl_enable),
    .ctrl_soft_rst (ctrl_soft_rst),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request driven at a falling edge, ack sampled at the next falling edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge aclk);
    wr_addr = a; wr_be = be; wr_data = d; wr_req = 1'b1;
    @(negedge aclk);
    wr_req = 1'b0;
    check("wr_ack", {31'd0, wr_ack}, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    @(negedge aclk);
    rd_addr = a; rd_req = 1'b1;
    @(negedge aclk);
    rd_req = 1'b0;
    check({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    areset = 1'b1;
    wr_addr = '0; wr_req = 1'b0; wr_be = '0; wr_data = '0;
    rd_addr = '0; rd_req = 1'b0; irq_event = '0; cnt_event = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_outputs", {26'd0, wr_ack, rd_ack, ctrl_enable, ctrl_soft_rst, irq, |rd_data}, 32'd0);
    areset = 1'b0;

    do_read("version", 10'h000, 32'h0001_0000);
    do_read("scratch_rst", 10'h001, 32'h0);
    do_read("evt_rst", 10'h005, 32'h0);

    // Byte-enabled SCRATCH writes; ack is a single-cycle pulse.
    do_write(10'h001, 4'b0101, 32'h1234_5678);
    @(negedge aclk);
    check("wr_ack_low", {31'd0, wr_ack}, 32'd0);
    check("rd_ack_low", {31'd0, rd_ack}, 32'd0);
    do_read("scratch_be0101", 10'h001, 32'h0034_0078);
    do_write(10'h001, 4'b1010, 32'h1122_3344);
    do_read("scratch_be1010", 10'h001, 32'h1134_3378);

    // CONTROL: enable bit and soft-reset pulse.
    do_write(10'h002, 4'b0001, 32'h3);
    check("soft_rst_pulse", {31'd0, ctrl_soft_rst}, 32'd1);
    check("ctrl_enable", {31'd0, ctrl_enable}, 32'd1);
    @(negedge aclk);
    check("soft_rst_end", {31'd0, ctrl_soft_rst}, 32'd0);
    do_read("control_rd", 10'h002, 32'h1);
    @(negedge aclk);
    wr_addr = 10'h002; wr_be = 4'b0001; wr_data = 32'h3; wr_req = 1'b1;
    @(negedge aclk);
    check("soft_rst_b2b_1", {31'd0, ctrl_soft_rst}, 32'd1);
    @(negedge aclk);
    wr_req = 1'b0;
    check("soft_rst_b2b_2", {31'd0, ctrl_soft_rst}, 32'd1);
    @(negedge aclk);
    check("soft_rst_b2b_end", {31'd0, ctrl_soft_rst}, 32'd0);
    do_write(10'h002, 4'b1110, 32'h0);
    check("ctrl_be_ignored", {31'd0, ctrl_enable}, 32'd1);
    check("soft_rst_be_ignored", {31'd0, ctrl_soft_rst}, 32'd0);
    do_write(10'h002, 4'b0001, 32'h0);
    check("ctrl_disable", {31'd0, ctrl_enable}, 32'd0);

    // Interrupts: registered irq, set-wins over W1C, be[0] gating.
    do_write(10'h004, 4'b1111, 32'h0000_0104);
    do_read("irq_enable_rd", 10'h004, 32'h0000_0004);
    @(negedge aclk);
    irq_event = 8'h05;
    @(negedge aclk);
    irq_event = 8'h00;
    check("irq_lat", {31'd0, irq}, 32'd0);
    @(negedge aclk);
    check("irq_set", {31'd0, irq}, 32'd1);
    do_read("irq_status_05", 10'h003, 32'h0000_0005);
    @(negedge aclk);
    wr_addr = 10'h003; wr_be = 4'b0001; wr_data = 32'h04; wr_req = 1'b1; irq_event = 8'h04;
    @(negedge aclk);
    wr_req = 1'b0; irq_event = 8'h00;
    do_read("irq_set_wins", 10'h003, 32'h0000_0005);
    check("irq_still_set", {31'd0, irq}, 32'd1);
    do_write(10'h003, 4'b1110, 32'h04);
    do_read("w1c_be_ignored", 10'h003, 32'h0000_0005);
    do_write(10'h003, 4'b0001, 32'h04);
    check("irq_clear_lat", {31'd0, irq}, 32'd1);
    @(negedge aclk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    do_read("irq_status_01", 10'h003, 32'h0000_0001);

    // Event counter: count, clear+event, be gating, saturation.
    @(negedge aclk);
    cnt_event = 1'b1;
    repeat (3) @(negedge aclk);
    cnt_event = 1'b0;
    do_read("evt_3", 10'h005, 32'd3);
    @(negedge aclk);
    wr_addr = 10'h005; wr_be = 4'b0001; wr_data = 32'h0; wr_req = 1'b1; cnt_event = 1'b1;
    @(negedge aclk);
    wr_req = 1'b0; cnt_event = 1'b0;
    do_read("evt_clear_event", 10'h005, 32'd1);
    do_write(10'h005, 4'b1110, 32'h0);
    do_read("evt_be_ignored", 10'h005, 32'd1);
    @(negedge aclk);
    force dut.evt_count = 32'hFFFF_FFFF;
    #1 release dut.evt_count;
    cnt_event = 1'b1;
    @(negedge aclk);
    cnt_event = 1'b0;
    do_read("evt_saturate", 10'h005, 32'hFFFF_FFFF);

    // Unmapped accesses and read/write collision.
    do_read("unmapped_rd", 10'h03F, 32'hDEAD_BEEF);
    do_write(10'h03F, 4'b1111, 32'hFFFF_FFFF);
    do_read("unmapped_wr_ignored", 10'h001, 32'h1134_3378);
    @(negedge aclk);
    wr_addr = 10'h001; wr_be = 4'b1111; wr_data = 32'hCAFE_F00D; wr_req = 1'b1;
    rd_addr = 10'h001; rd_req = 1'b1;
    @(negedge aclk);
    wr_req = 1'b0; rd_req = 1'b0;
    check("collide_wr_ack", {31'd0, wr_ack}, 32'd1);
    check("collide_rd_old", rd_data, 32'h1134_3378);
    @(negedge aclk);
    check("rd_data_hold", rd_data, 32'h1134_3378);
    do_read("collide_new", 10'h001, 32'hCAFE_F00D);

    // Asynchronous reset while a request is in flight.
    do_write(10'h002, 4'b0001, 32'h1);
    @(negedge aclk);
    irq_event = 8'h04;
    @(negedge aclk);
    irq_event = 8'h00;
    wr_addr = 10'h001; wr_be = 4'b1111; wr_data = 32'h5555_AAAA; wr_req = 1'b1;
    rd_addr = 10'h001; rd_req = 1'b1;
    @(posedge aclk);
    #1;
    check("pre_rst_busy", {28'd0, wr_ack, rd_ack, ctrl_enable, irq}, 32'hF);
    areset = 1'b1;
    #1;
    check("async_rst_ctl", {27'd0, wr_ack, rd_ack, ctrl_enable, ctrl_soft_rst, irq}, 32'd0);
    check("async_rst_rdata", rd_data, 32'd0);
    @(negedge aclk);
    check("rst_no_ack", {30'd0, wr_ack, rd_ack}, 32'd0);
    wr_req = 1'b0; rd_req = 1'b0;
    areset = 1'b0;
    do_read("post_rst_scratch", 10'h001, 32'h0);
    do_read("post_rst_status", 10'h003, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4l_regbank.md
AXI4L_REGBANK -- requirements
Module: axi4l_regbank

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 12: byte-address width; word address is C_ADDR_WIDTH-2 bits.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32: data width; only 32 is legal, and elaboration SHALL error otherwise.
REQ-003 SHALL have parameter C_VERSION, default 32'h0001_0000: constant returned by the VERSION register.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; all logic runs on that one clock.
REQ-005 aclk  in  1  clock.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 wr_addr  in  C_ADDR_WIDTH-2  word address, valid with wr_req.
REQ-008 wr_req  in  1  single-cycle write request pulse.
REQ-009 wr_be  in  4  byte enables.
REQ-010 wr_data  in  32  write data.
REQ-011 wr_ack  out  1  write acknowledge pulse.
REQ-012 rd_addr  in  C_ADDR_WIDTH-2  word address, valid with rd_req.
REQ-013 rd_req  in  1  single-cycle read request pulse.
REQ-014 rd_data  out  32  read data, valid while rd_ack=1.
REQ-015 rd_ack  out  1  read acknowledge pulse.
REQ-016 irq_event  in  8  per-bit event pulses that set the interrupt status bits.
REQ-017 cnt_event  in  1  event pulse counted by EVT_COUNT.
REQ-018 ctrl_enable  out  1  CONTROL[0].
REQ-019 ctrl_soft_rst  out  1  one-cycle pulse generated by writing CONTROL[1]=1.
REQ-020 irq  out  1  registered interrupt output, equal to OR over (IRQ_STATUS & IRQ_ENABLE).

Function
REQ-021 Register map (word address):
- 0 VERSION: RO.
- 1 SCRATCH: RW, 32 bits, byte-enabled.
- 2 CONTROL: bit0 RW; bit1 write-1 pulse, reads 0.
- 3 IRQ_STATUS: [7:0] W1C.
- 4 IRQ_ENABLE: [7:0] RW.
- 5 EVT_COUNT: RO; any write clears it.
REQ-022 Unused bits SHALL read 0.
REQ-023 Write handling: wr_ack SHALL pulse for exactly 1 cycle, 1 cycle after wr_req (latency 1); the register update SHALL be visible from that same cycle.
REQ-024 Read handling: rd_ack and rd_data SHALL be registered 1 cycle after rd_req; rd_data SHALL hold its value until the next read.
REQ-025 Every address SHALL be acknowledged. Writes to unmapped addresses are ignored. Reads from unmapped addresses return 32'hDEAD_BEEF.
REQ-026 wr_be SHALL gate SCRATCH per byte. For CONTROL and IRQ_ENABLE, only be[0] SHALL be honoured. IRQ_STATUS W1C and EVT_COUNT clear SHALL require be[0] and ignore the other enables.
REQ-027 wr_req and rd_req asserted in the same cycle SHALL both be serviced in parallel; the read SHALL return the pre-write value.
REQ-028 IRQ_STATUS bit n SHALL set on irq_event[n]. If set and W1C occur in the same cycle, set SHALL win.
REQ-029 irq SHALL be registered, so it asserts 1 cycle after the status/enable update.
REQ-030 EVT_COUNT SHALL increment on cnt_event and saturate at 32'hFFFF_FFFF. If a clear and an event occur in the same cycle, the result SHALL be 1.
REQ-031 ctrl_soft_rst SHALL assert in the cycle wr_ack asserts and deassert the next cycle; back-to-back writes SHALL yield back-to-back pulses.
REQ-032 A request SHALL be sampled only while wr_req/rd_req=1; there is no outstanding state beyond the 1-cycle ack pipeline.

Reset
REQ-033 areset SHALL asynchronously clear wr_ack, rd_ack, rd_data, SCRATCH, CONTROL, IRQ_STATUS, IRQ_ENABLE, EVT_COUNT, ctrl_enable, ctrl_soft_rst and irq to 0.
REQ-034 A request that is in flight when reset asserts SHALL be dropped with no ack.
REQ-035 Release of areset SHALL be synchronised externally; the block SHALL accept requests from the first cycle after release.

Structure
REQ-036 Package axi4l_regbank_pkg SHALL hold the register address constants, the unmapped read value 32'hDEAD_BEEF, the CONTROL bit indices and the default C_VERSION.
REQ-037 Sub-module axi4l_regbank_irq SHALL own IRQ_STATUS, IRQ_ENABLE and irq; the top SHALL own decode, the ack pipeline and the remaining registers.

Verification
REQ-038 Write SCRATCH 32'h1234_5678 with be=4'b0101, then read it back: rd_data=32'h0034_0078, and rd_ack arrives 1 cycle after rd_req.
REQ-039 Pulse irq_event=8'h05 with IRQ_ENABLE=8'h04: irq=1. Then W1C 8'h04 in the same cycle as irq_event[2]=1: status stays 8'h05 and irq stays 1.
REQ-040 Apply 3 cnt_event pulses: EVT_COUNT=3. Clear together with an event: EVT_COUNT=1. Force the counter to 32'hFFFF_FFFF and apply an event: it stays 32'hFFFF_FFFF.
REQ-041 Write CONTROL 32'h3: ctrl_enable=1 and ctrl_soft_rst is a 1-cycle pulse; a read of CONTROL returns 32'h1.
REQ-042 Read address 0x3F: rd_data=32'hDEAD_BEEF with ack. Read VERSION: rd_data=C_VERSION. Issue a simultaneous read and write of SCRATCH: the read returns the old value.
REQ-043 Assert areset mid-request: no ack is generated and all outputs are 0 immediately, without waiting for a clock edge.
